// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants and lane offset helper for the 1-to-4 demux.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int unsigned SEL_W     = 2;
    localparam int unsigned NUM_LANES = 4;

    function automatic int unsigned lane_slice(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_2to4.sv
`default_nettype none
// ============================================================================
// Module   : dec_2to4
// Brief    : Combinational 2-to-4 one-hot decoder for lane selection.
// Revision : 1.0
// ============================================================================
module dec_2to4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]     sel_i,
    output logic [NUM_LANES-1:0] lane_en_o
);

    assign lane_en_o = {{(NUM_LANES-1){1'b0}}, 1'b1} << sel_i;

endmodule
`default_nettype wire

// File: rtl/demux_1to4_sva.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_sva
// Brief    : Bindable assertion checker for demux_1to4.
// Revision : 1.0
// ============================================================================
module demux_1to4_sva
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic [SEL_W-1:0]           s,
    input logic [NUM_LANES*WIDTH-1:0] y
);

    logic [NUM_LANES-1:0] lane_nz;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_nz
        assign lane_nz[k] = |y[lane_slice(k, WIDTH) +: WIDTH];
    end

    a_sel_known : assert property (@(posedge clk) rst_n |-> !$isunknown(s));
    a_one_lane  : assert property (@(posedge clk) $onehot0(lane_nz));

endmodule
`default_nettype wire

// File: rtl/demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4
// Brief    : Registered 1-to-4 demultiplexer; unselected lanes are zeroed.
// Revision : 1.0
// ============================================================================
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           d,
    input  logic [SEL_W-1:0]           s,
    output logic [NUM_LANES*WIDTH-1:0] y
);

    logic [NUM_LANES-1:0]       lane_en;
    logic [NUM_LANES*WIDTH-1:0] y_d;
    logic [NUM_LANES*WIDTH-1:0] y_q;

    dec_2to4 u_dec (
        .sel_i     (s),
        .lane_en_o (lane_en)
    );

    // Masking (rather than holding) guarantees only the selected lane is non-zero.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign y_d[lane_slice(k, WIDTH) +: WIDTH] = d & {WIDTH{lane_en[k]}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4
// Brief    : Self-checking bench for demux_1to4 at WIDTH=1 and WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_demux_1to4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d1;
    logic [7:0]  d8;
    logic [1:0]  s;
    logic [3:0]  y1;
    logic [31:0] y8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_1to4 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .d(d1), .s(s), .y(y1));
    demux_1to4 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .d(d8), .s(s), .y(y8));

    demux_1to4_sva #(.WIDTH(1)) u_sva1 (.clk(clk), .rst_n(rst_n), .s(s), .y(y1));
    demux_1to4_sva #(.WIDTH(8)) u_sva8 (.clk(clk), .rst_n(rst_n), .s(s), .y(y8));

    // Reference: data shifted into lane s, or nothing while in reset.
    function automatic logic [3:0] model1(input logic r, input logic dd, input logic [1:0] ss);
        if (!r) return 4'h0;
        return 4'(dd) << ss;
    endfunction

    function automatic logic [31:0] model8(input logic r, input logic [7:0] dd, input logic [1:0] ss);
        if (!r) return 32'h0;
        return 32'(dd) << (8 * int'(ss));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check just after the rising edge.
    task automatic apply(input string tag, input logic r, input logic dd1,
                         input logic [7:0] dd8, input logic [1:0] ss);
        logic [3:0]  e1;
        logic [31:0] e8;
        @(negedge clk);
        rst_n = r;
        d1    = dd1;
        d8    = dd8;
        s     = ss;
        e1    = model1(r, dd1, ss);
        e8    = model8(r, dd8, ss);
        @(posedge clk);
        #1;
        check({tag, "_w1"}, 32'(y1), 32'(e1));
        check({tag, "_w8"}, y8, e8);
    endtask

    initial begin
        rst_n = 1'b0;
        d1    = 1'b1;
        d8    = 8'hA5;
        s     = 2'd2;

        apply("reset0", 1'b0, 1'b1, 8'hA5, 2'd2);
        apply("reset1", 1'b0, 1'b1, 8'hA5, 2'd2);
        apply("release", 1'b1, 1'b1, 8'hA5, 2'd2);
        check("release_lit", 32'(y1), 32'h4);

        for (int i = 0; i < 4; i++) apply("d0_sweep", 1'b1, 1'b0, 8'h00, 2'(i));
        for (int i = 0; i < 4; i++) begin
            apply("d1_sweep", 1'b1, 1'b1, 8'h01, 2'(i));
            check("d1_sweep_lit", 32'(y1), 32'(1) << i);
        end

        // Between-edge toggles on s must not reach y.
        apply("glitch_base", 1'b1, 1'b1, 8'h3C, 2'd0);
        @(negedge clk);
        s = 2'd1;
        #1 check("glitch_hold1", 32'(y1), 32'h1);
        s = 2'd2;
        #1 check("glitch_hold2", y8, 32'h0000_003C);
        s = 2'd3;
        @(posedge clk);
        #1;
        check("glitch_settle", 32'(y1), 32'h8);
        check("glitch_settle_w8", y8, 32'h3C00_0000);

        apply("stream", 1'b1, 1'b1, 8'h77, 2'd1);
        apply("midrst", 1'b0, 1'b1, 8'h77, 2'd1);
        apply("midrst_rel", 1'b1, 1'b1, 8'h77, 2'd1);
        check("midrst_rel_lit", 32'(y1), 32'h2);

        apply("w8_s2", 1'b1, 1'b1, 8'hA5, 2'd2);
        check("w8_s2_lit", y8, 32'h00A5_0000);
        apply("w8_s0", 1'b1, 1'b1, 8'hA5, 2'd0);
        check("w8_s0_lit", y8, 32'h0000_00A5);

        for (int i = 0; i < 300; i++) begin
            apply("rand", ($urandom_range(9) != 0), 1'($urandom), 8'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
